// File: rtl/ysyx_25060173_wbu.sv
// ysyx_25060173_wbu -- write-back unit.
//
// Accepts one instruction result at a time, optionally waits for load data
// from memory, then drives a single-cycle register-file write and a commit
// pulse. Three states: IDLE (accepting), WAIT_MEM (load data pending), and
// WRITE (write port active for one cycle).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream result handshake (ready only in IDLE)
//   in_rd, in_rd_we     destination index and write enable
//   in_sel              result source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR
//   in_alu/pc4/csr      candidate results; in_alu[1:0] is the load byte offset
//   in_ld_size          0 byte, 1 half, 2/3 word
//   in_ld_unsigned      zero-extend sub-word loads when 1
//   mem_rvalid/rready   load-data handshake, mem_rdata the raw word
//   rf_we/waddr/wdata   register-file write port (x0 writes suppressed)
//   commit              one-cycle pulse per retired instruction
//
// Optional feature (macro YSYX_25060173_WBU_BYPASS_EN): adds byp_valid,
// byp_addr and byp_data, which mirror the write port during WRITE and are 0
// otherwise, for operand forwarding.
module ysyx_25060173_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic [1:0]            in_sel,
  input  logic [DATA_WIDTH-1:0] in_alu,
  input  logic [DATA_WIDTH-1:0] in_pc4,
  input  logic [DATA_WIDTH-1:0] in_csr,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_rready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit
`ifdef YSYX_25060173_WBU_BYPASS_EN
  ,
  output logic                  byp_valid,
  output logic [ADDR_WIDTH-1:0] byp_addr,
  output logic [DATA_WIDTH-1:0] byp_data
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_LD  = 2'd1;
  localparam logic [1:0] SEL_PC4 = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic                  r_rd_we;
  logic [1:0]            r_sel;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_pc4;
  logic [DATA_WIDTH-1:0] r_csr;
  logic [1:0]            r_ld_size;
  logic                  r_ld_unsigned;
  logic [DATA_WIDTH-1:0] r_ld_data;

  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_wr;

  // Sub-word extraction uses the offset latched with the request, not the
  // live in_alu, since upstream may already be presenting the next result.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_alu[1:0])
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      2'd3: w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    // Half loads ignore offset bit 0 (no misaligned halves).
    w_half = r_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_ld_size)
      2'd0:    w_ld_data = {{(DATA_WIDTH-8){w_byte[7] & ~r_ld_unsigned}}, w_byte};
      2'd1:    w_ld_data = {{(DATA_WIDTH-16){w_half[15] & ~r_ld_unsigned}}, w_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    case (r_sel)
      SEL_ALU: w_result = r_alu;
      SEL_LD:  w_result = r_ld_data;
      SEL_PC4: w_result = r_pc4;
      default: w_result = r_csr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rd          <= '0;
      r_rd_we       <= 1'b0;
      r_sel         <= SEL_ALU;
      r_alu         <= '0;
      r_pc4         <= '0;
      r_csr         <= '0;
      r_ld_size     <= 2'd0;
      r_ld_unsigned <= 1'b0;
      r_ld_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_rd          <= in_rd;
          r_rd_we       <= in_rd_we;
          r_sel         <= in_sel;
          r_alu         <= in_alu;
          r_pc4         <= in_pc4;
          r_csr         <= in_csr;
          r_ld_size     <= in_ld_size;
          r_ld_unsigned <= in_ld_unsigned;
          r_state       <= (in_sel == SEL_LD) ? S_WAIT : S_WRITE;
        end
        S_WAIT: if (mem_rvalid) begin
          r_ld_data <= w_ld_data;
          r_state   <= S_WRITE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are qualified with rst_n so that the reset values hold while
  // reset is asserted, even before the reset edge reaches the state register.
  assign w_wr       = (r_state == S_WRITE) && rst_n;
  assign in_ready   = (r_state == S_IDLE) || !rst_n;
  assign mem_rready = (r_state == S_WAIT) && rst_n;
  assign rf_we      = w_wr && r_rd_we && (r_rd != '0);
  assign rf_waddr   = w_wr ? r_rd : '0;
  assign rf_wdata   = w_wr ? w_result : '0;
  assign commit     = w_wr;

`ifdef YSYX_25060173_WBU_BYPASS_EN
  assign byp_valid = rf_we;
  assign byp_addr  = rf_waddr;
  assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_ysyx_25060173_wbu.sv
// Self-checking bench for ysyx_25060173_wbu: directed literal cases followed
// by a randomized run, all compared every cycle against a transaction-level
// model of the write-back unit.
module tb_ysyx_25060173_wbu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_rd_we = 1'b0;
  logic [1:0]  in_sel = '0;
  logic [31:0] in_alu = '0, in_pc4 = '0, in_csr = '0;
  logic [1:0]  in_ld_size = '0;
  logic        in_ld_unsigned = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
`ifdef YSYX_25060173_WBU_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_addr;
  logic [31:0] byp_data;
`endif

  ysyx_25060173_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_sel(in_sel), .in_alu(in_alu),
    .in_pc4(in_pc4), .in_csr(in_csr), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rready(mem_rready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit(commit)
`ifdef YSYX_25060173_WBU_BYPASS_EN
    , .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction in flight: phase 0 = nothing held, 1 = load awaiting
  // memory, 2 = result ready to be written this cycle.
  int          m_phase = 0;
  logic [4:0]  m_rd;
  bit          m_we;
  logic [31:0] m_val;
  int          m_off, m_size;
  bit          m_uns;

  function automatic logic [31:0] ld_ext(input logic [31:0] d, input int off,
                                         input int size, input bit uns);
    logic [31:0] v;
    if (size == 0) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_rd = in_rd;
        m_we = in_rd_we;
        m_off = int'(in_alu[1:0]);
        m_size = int'(in_ld_size);
        m_uns = in_ld_unsigned;
        if (in_sel == 2'd0)      m_val = in_alu;
        else if (in_sel == 2'd2) m_val = in_pc4;
        else if (in_sel == 2'd3) m_val = in_csr;
        m_phase = (in_sel == 2'd1) ? 1 : 2;
      end
    end else if (m_phase == 1) begin
      if (mem_rvalid) begin
        m_val = ld_ext(mem_rdata, m_off, m_size, m_uns);
        m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  // Compare process: outputs checked mid-cycle, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit w;
      w = rst_n && (m_phase == 2);
      check("in_ready",   in_ready,   (!rst_n || m_phase == 0));
      check("mem_rready", mem_rready, (rst_n && m_phase == 1));
      check("commit",     commit,     w);
      check("rf_we",      rf_we,      (w && m_we && m_rd != 0));
      check("rf_waddr",   rf_waddr,   w ? m_rd : 5'd0);
      check("rf_wdata",   rf_wdata,   w ? m_val : 32'd0);
`ifdef YSYX_25060173_WBU_BYPASS_EN
      check("byp_valid",  byp_valid,  (w && m_we && m_rd != 0));
      check("byp_addr",   byp_addr,   w ? m_rd : 5'd0);
      check("byp_data",   byp_data,   w ? m_val : 32'd0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] csr, input logic [1:0] sz, input logic uns);
    in_valid = 1'b1; in_sel = sel; in_rd = rd; in_rd_we = we;
    in_alu = alu; in_pc4 = pc4; in_csr = csr; in_ld_size = sz; in_ld_unsigned = uns;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    @(negedge clk);
    check("rst in_ready", in_ready, 1'b1);
    check("rst mem_rready", mem_rready, 1'b0);
    check("rst rf_we", rf_we, 1'b0);
    check("rst commit", commit, 1'b0);
    check("rst rf_waddr", rf_waddr, 5'd0);
    check("rst rf_wdata", rf_wdata, 32'd0);
    rst_n = 1'b1;
    cyc();

    // ALU write
    issue(2'd0, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    check("alu rf_we", rf_we, 1'b1);
    check("alu waddr", rf_waddr, 5'd5);
    check("alu wdata", rf_wdata, 32'h1234_5678);
    check("alu commit", commit, 1'b1);
    cyc();
    @(negedge clk);
    check("alu commit gone", commit, 1'b0);
    check("alu ready back", in_ready, 1'b1);
    cyc();

    // Signed byte load at offset 3 with three stall cycles
    issue(2'd1, 5'd3, 1'b1, 32'h0000_0003, 32'h0, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lb stall in_ready", in_ready, 1'b0);
      check("lb stall rready", mem_rready, 1'b1);
      check("lb stall commit", commit, 1'b0);
      cyc();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
    @(negedge clk);
    check("lb rvalid in_ready", in_ready, 1'b0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("lb wdata", rf_wdata, 32'hFFFF_FF80);
    check("lb waddr", rf_waddr, 5'd3);
    check("lb rf_we", rf_we, 1'b1);
    cyc();

    // Unsigned half load at offset 2
    issue(2'd1, 5'd9, 1'b1, 32'h0000_0002, 32'h0, 32'h0, 2'd1, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0001;
    cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("lhu wdata", rf_wdata, 32'h0000_BEEF);
    cyc();

    // Write to x0 is dropped but still commits
    issue(2'd2, 5'd0, 1'b1, 32'h0, 32'h8000_0004, 32'h0, 2'd0, 1'b0);
    @(negedge clk);
    check("x0 rf_we", rf_we, 1'b0);
    check("x0 commit", commit, 1'b1);
    cyc();

`ifdef YSYX_25060173_WBU_BYPASS_EN
    issue(2'd3, 5'd7, 1'b1, 32'h0, 32'h0, 32'hA5A5_A5A5, 2'd0, 1'b0);
    @(negedge clk);
    check("byp valid", byp_valid, 1'b1);
    check("byp addr", byp_addr, 5'd7);
    check("byp data", byp_data, 32'hA5A5_A5A5);
    cyc();
    @(negedge clk);
    check("byp valid after", byp_valid, 1'b0);
    cyc();
`endif

    // Reset during WAIT_MEM discards the load
    issue(2'd1, 5'd4, 1'b1, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    check("rstwait in_ready", in_ready, 1'b1);
    check("rstwait rready", mem_rready, 1'b0);
    cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("rstwait rf_we", rf_we, 1'b0);
    check("rstwait commit", commit, 1'b0);
    cyc();

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      in_valid       = $urandom_range(0, 1);
      in_sel         = 2'($urandom_range(0, 3));
      in_rd          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      in_rd_we       = ($urandom_range(0, 4) != 0);
      in_alu         = $urandom;
      in_pc4         = $urandom;
      in_csr         = $urandom;
      in_ld_size     = 2'($urandom_range(0, 3));
      in_ld_unsigned = $urandom_range(0, 1);
      mem_rvalid     = ($urandom_range(0, 9) < 4);
      mem_rdata      = $urandom;
      cyc();
    end
    in_valid = 1'b0; mem_rvalid = 1'b0; rst_n = 1'b1;
    cyc();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
